// File: rtl/pulse_burst_classifier_pkg.sv
// pulse_burst_classifier_pkg: shared FSM state type and default burst parameters
package pulse_burst_classifier_pkg;
  typedef enum logic {ST_IDLE = 1'b0, ST_COLLECT = 1'b1} state_e;
  localparam int DEF_WINDOW = 20;
  localparam int DEF_MAX_COUNT = 7;
endpackage

// File: rtl/pulse_burst_classifier_timer.sv
// burst_window_timer: idle-cycle counter that flags the last cycle of a burst window
module burst_window_timer #(
  parameter int WINDOW = 20
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic advance,
  output logic expired
);
  localparam int TW = $clog2(WINDOW);
  logic [TW-1:0] timer_q, timer_d;
  always_comb timer_d = clear ? '0 : advance ? timer_q + 1'b1 : timer_q;
  always_ff @(posedge clk or posedge rst)
    if (rst) timer_q <= '0;
    else     timer_q <= timer_d;
  assign expired = timer_q == TW'(WINDOW - 1);
endmodule

// File: rtl/pulse_burst_classifier.sv
// pulse_burst_classifier: groups closely spaced press strobes into counted bursts
module pulse_burst_classifier
  import pulse_burst_classifier_pkg::*;
#(
  parameter int  WINDOW    = DEF_WINDOW,
  parameter int  MAX_COUNT = DEF_MAX_COUNT,
  localparam int CNT_W     = $clog2(MAX_COUNT + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pulse,
  input  logic             evt_ready,
  output logic             evt_valid,
  output logic [CNT_W-1:0] evt_count,
  output logic             evt_sat,
  output logic             overrun,
  output logic             busy
);
  state_e state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d, evt_count_q, evt_count_d;
  logic sat_q, sat_d, evt_valid_q, evt_valid_d, evt_sat_q, evt_sat_d, overrun_d, overrun_q;
  logic expired, at_max, close;
  burst_window_timer #(.WINDOW(WINDOW)) u_timer (
    .clk     (clk),
    .rst     (rst),
    .clear   (pulse | expired),
    .advance (state_q == ST_COLLECT),
    .expired (expired)
  );
  assign at_max = count_q == CNT_W'(MAX_COUNT);
  always_comb begin
    state_d     = state_q;
    count_d     = count_q;
    sat_d       = sat_q;
    close       = 1'b0;
    evt_valid_d = evt_valid_q;
    evt_count_d = evt_count_q;
    evt_sat_d   = evt_sat_q;
    overrun_d   = 1'b0;
    if (state_q == ST_IDLE) begin
      if (pulse) begin
        state_d = ST_COLLECT;
        count_d = CNT_W'(1);
        sat_d   = MAX_COUNT == 1;
      end
    end else if (pulse) begin
      count_d = at_max ? count_q : count_q + 1'b1;
      sat_d   = at_max || (count_q + 1'b1) == CNT_W'(MAX_COUNT);
    end else if (expired) begin
      state_d = ST_IDLE;
      count_d = '0;
      close   = 1'b1;
    end
    // a held event is only replaced when the consumer takes it this same cycle
    if (close && (!evt_valid_q || evt_ready)) begin
      evt_valid_d = 1'b1;
      evt_count_d = count_q;
      evt_sat_d   = sat_q;
    end else if (close) begin
      overrun_d = 1'b1;
    end else if (evt_valid_q && evt_ready) begin
      evt_valid_d = 1'b0;
    end
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q     <= ST_IDLE;
      count_q     <= '0;
      sat_q       <= 1'b0;
      evt_valid_q <= 1'b0;
      evt_count_q <= '0;
      evt_sat_q   <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      sat_q       <= sat_d;
      evt_valid_q <= evt_valid_d;
      evt_count_q <= evt_count_d;
      evt_sat_q   <= evt_sat_d;
      overrun_q   <= overrun_d;
    end
  assign evt_valid = evt_valid_q;
  assign evt_count = evt_count_q;
  assign evt_sat   = evt_sat_q;
  assign overrun   = overrun_q;
  assign busy      = state_q == ST_COLLECT;
endmodule
